// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two
// requesters. The winning request is registered, the ALU is driven from those
// registers, the result is captured and returned on a tagged valid/ready port.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-low reset
//   req{0,1}_valid_i/op_i/a_i/b_i  request inputs per requester
//   req{0,1}_ready_o        combinational accept strobe (IDLE only)
//   rsp_valid_o/ready_i     response handshake
//   rsp_id_o, rsp_result_o  owning requester and registered result
//   alu_op_o/a_o/b_o        to ALU, straight from the captured request
//   alu_result_i            combinational ALU result
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [OP_WIDTH-1:0]   req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [OP_WIDTH-1:0]   req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  id_q, id_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  grant0, grant1;

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      IDLE: begin
        // Tie goes to whoever did not win last time.
        grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
        grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
        if (grant0) begin
          op_d         = req0_op_i;
          a_d          = req0_a_i;
          b_d          = req0_b_i;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (grant1) begin
          op_d         = req1_op_i;
          a_d          = req1_a_i;
          b_d          = req1_b_i;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_result_i;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // Ready is held low while reset is asserted, even before the reset edge.
  assign req0_ready_o = reset & grant0;
  assign req1_ready_o = reset & grant1;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model plus directed scenarios.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, also used as the ALU attached to the DUT.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b;
      4'd3:    return a | b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one request in flight, age 1 = executing, age >=2 = responding.
  bit          m_init = 0;
  bit          m_in_reset = 0;
  bit          m_busy = 0;
  int          m_age = 0;
  logic        m_id = 1'b0;
  logic        m_last = 1'b1;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;

  function automatic logic exp_g0();
    return reset && !m_busy && req0_valid && (!req1_valid || m_last);
  endfunction
  function automatic logic exp_g1();
    return reset && !m_busy && req1_valid && (!req0_valid || !m_last);
  endfunction

  always @(posedge clk) begin
    m_init = 1;
    m_in_reset = !reset;
    if (!reset) begin
      m_busy = 0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
      m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
    end else if (!m_busy) begin
      if (exp_g0()) begin
        m_busy = 1; m_age = 1; m_id = 1'b0; m_last = 1'b0;
        m_op = req0_op; m_a = req0_a; m_b = req0_b;
      end else if (exp_g1()) begin
        m_busy = 1; m_age = 1; m_id = 1'b1; m_last = 1'b1;
        m_op = req1_op; m_a = req1_a; m_b = req1_b;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rsp_ready) begin
      m_busy = 0;
    end
  end

  // Completed responses as seen on the port.
  logic        log_id[$];
  logic [31:0] log_res[$];

  // Per-cycle compare against the model; also logs handshakes.
  always @(negedge clk) begin
    if (m_init) begin
      chk("ready0", 32'(req0_ready), 32'(exp_g0()));
      chk("ready1", 32'(req1_ready), 32'(exp_g1()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (m_busy && m_age >= 2) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_result", rsp_result, alu_f(m_op, m_a, m_b));
      end
      if (m_in_reset) begin
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
      end
      if (rsp_valid && rsp_ready && reset) begin
        log_id.push_back(rsp_id);
        log_res.push_back(rsp_result);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  int base;
  int cnt;

  initial begin
    reset = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, 4'd0, 32'd5, 32'd7);
    set1(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset: everything quiet even with a valid request pending.
    repeat (3) tick();
    @(negedge clk);
    chk("lit_rst_ready0", 32'(req0_ready), 32'd0);
    chk("lit_rst_valid", 32'(rsp_valid), 32'd0);
    chk("lit_rst_alu_a", alu_a, 32'd0);
    chk("lit_rst_result", rsp_result, 32'd0);

    // ADD 5+7 from requester 0.
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_add_ready0", 32'(req0_ready), 32'd1);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("lit_add_exec_a", alu_a, 32'd5);
    chk("lit_add_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lit_add_valid", 32'(rsp_valid), 32'd1);
    chk("lit_add_id", 32'(rsp_id), 32'd0);
    chk("lit_add_result", rsp_result, 32'd12);
    tick();
    @(negedge clk);
    chk("lit_add_done", 32'(rsp_valid), 32'd0);

    // Both valid from reset: alternate 0,1,0,1.
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set0(1'b1, 4'd1, 32'd10, 32'd3);
    set1(1'b1, 4'd3, 32'h0000_00F0, 32'h0000_000F);
    base = log_id.size();
    for (int i = 0; i < 60 && log_id.size() < base + 4; i++) tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    chk("lit_rr_count", 32'(log_id.size() - base), 32'd4);
    if (log_id.size() >= base + 4) begin
      chk("lit_rr_id0", 32'(log_id[base]), 32'd0);
      chk("lit_rr_res0", log_res[base], 32'd7);
      chk("lit_rr_id1", 32'(log_id[base+1]), 32'd1);
      chk("lit_rr_res1", log_res[base+1], 32'h0000_00FF);
      chk("lit_rr_id2", 32'(log_id[base+2]), 32'd0);
      chk("lit_rr_id3", 32'(log_id[base+3]), 32'd1);
    end
    repeat (3) tick();

    // Backpressure on requester 1 SLL 1<<4, requester 0 waiting meanwhile.
    rsp_ready = 1'b0;
    set1(1'b1, 4'd4, 32'd1, 32'd4);
    @(negedge clk);
    chk("lit_bp_ready1", 32'(req1_ready), 32'd1);
    tick();
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    set0(1'b1, 4'd0, 32'd1, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_bp_valid", 32'(rsp_valid), 32'd1);
      chk("lit_bp_result", rsp_result, 32'd16);
      chk("lit_bp_id", 32'(rsp_id), 32'd1);
      chk("lit_bp_ready0", 32'(req0_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("lit_bp_release", 32'(rsp_valid), 32'd0);
    chk("lit_bp_next_ready0", 32'(req0_ready), 32'd1);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();

    // Reset during EXEC of SRL 0x80>>3.
    set0(1'b1, 4'd5, 32'h80, 32'd3);
    @(negedge clk);
    chk("lit_mid_ready0", 32'(req0_ready), 32'd1);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("lit_mid_exec_op", 32'(alu_op), 32'd5);
    tick();
    @(negedge clk);
    chk("lit_mid_valid", 32'(rsp_valid), 32'd0);
    chk("lit_mid_alu_op", 32'(alu_op), 32'd0);
    tick();
    reset = 1'b1;
    set0(1'b1, 4'd0, 32'd1, 32'd2);
    set1(1'b1, 4'd0, 32'd3, 32'd4);
    @(negedge clk);
    chk("lit_mid_tie_ready0", 32'(req0_ready), 32'd1);
    chk("lit_mid_tie_ready1", 32'(req1_ready), 32'd0);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();

    // Withdrawal of requester 1 while a response is stalled.
    rsp_ready = 1'b0;
    set0(1'b1, 4'd0, 32'd2, 32'd3);
    @(negedge clk);
    chk("lit_wd_ready0", 32'(req0_ready), 32'd1);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    set1(1'b1, 4'd3, 32'd1, 32'd2);
    @(negedge clk);
    chk("lit_wd_ready1", 32'(req1_ready), 32'd0);
    tick();
    set1(1'b0, 4'd0, 32'd0, 32'd0);
    base = log_id.size();
    tick();
    rsp_ready = 1'b1;
    repeat (4) tick();
    cnt = 0;
    for (int i = base; i < log_id.size(); i++) if (log_id[i]) cnt++;
    chk("lit_wd_id1_count", 32'(cnt), 32'd0);
    chk("lit_wd_rsp_count", 32'(log_id.size() - base), 32'd1);
    if (log_id.size() > base) chk("lit_wd_result", log_res[base], 32'd5);

    // LUI passes operand B through the ALU.
    set0(1'b1, 4'd2, 32'hDEAD_BEEF, 32'h1234_5000);
    @(negedge clk);
    chk("lit_lui_ready0", 32'(req0_ready), 32'd1);
    tick();
    set0(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("lit_lui_alu_op", 32'(alu_op), 32'd2);
    chk("lit_lui_alu_b", alu_b, 32'h1234_5000);
    tick();
    @(negedge clk);
    chk("lit_lui_valid", 32'(rsp_valid), 32'd1);
    chk("lit_lui_result", rsp_result, 32'h1234_5000);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
